// File: rtl/otter_ctrl_pkg.sv
`default_nettype none
// otter_ctrl_pkg: shared opcode/state encodings and operand-B selects for the OTTER control path.
// Revision 1.0
package otter_ctrl_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_INTR  = 3'd4
   } state_t;

   localparam logic [2:0]  SRCB_RS2   = 3'd0;
   localparam logic [2:0]  SRCB_ITYPE = 3'd1;
   localparam logic [2:0]  SRCB_STYPE = 3'd2;
   localparam logic [2:0]  SRCB_PC    = 3'd3;
   localparam logic [2:0]  SRCB_CSR   = 3'd4;
   localparam logic [11:0] MRET_IMM   = 12'h302;

   // CSRRW / CSRRS / CSRRC; the immediate CSR forms are not supported.
   function automatic logic is_csr_f3(input logic [2:0] f3);
      return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_srcb_dec.sv
`default_nettype none
// ctrl_srcb_dec: combinational opcode/funct3 decode to the ALU operand-B select.
// Revision 1.0
module ctrl_srcb_dec
   import otter_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   output logic [2:0] srcb_o
);

   always_comb begin
      srcb_o = SRCB_RS2;
      case (opcode_i)
         OPC_OP_IMM, OPC_JAL, OPC_JALR, OPC_LOAD: srcb_o = SRCB_ITYPE;
         OPC_STORE:                               srcb_o = SRCB_STYPE;
         OPC_AUIPC:                               srcb_o = SRCB_PC;
         // CSRRW passes rs1 straight through; the set/clear forms combine with the old CSR value.
         OPC_SYSTEM: begin
            if (funct3_i == 3'b010 || funct3_i == 3'b011)
               srcb_o = SRCB_CSR;
         end
         default:                                 srcb_o = SRCB_RS2;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/otter_exec_sequencer.sv
`default_nettype none
// otter_exec_sequencer: multicycle FETCH/EXEC/MEM/INTR sequencer driving OTTER datapath strobes.
// Revision 1.0
module otter_exec_sequencer
   import otter_ctrl_pkg::*;
#(
   parameter int MEM_TO_CYCLES = 16,
   parameter int TO_W          = 5
)(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [31:0] ir,
   input  logic        mem_ack,
   input  logic        intr,
   input  logic        csr_mie,
   output logic [2:0]  srcB_SEL,
   output logic        pc_we,
   output logic        rf_we,
   output logic        mem_rden1,
   output logic        mem_rden2,
   output logic        mem_we2,
   output logic        csr_we,
   output logic        int_taken,
   output logic        mret_exec,
   output logic        bus_err,
   output logic        ill_err
);

   state_t            state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [2:0]        w_srcb_dec;
   logic              w_timeout;
   logic              w_irq;
   logic              unused_ir_bits;

   assign unused_ir_bits = ^{ir[19:15], ir[11:7]};

   ctrl_srcb_dec u_srcb_dec (
      .opcode_i (ir[6:0]),
      .funct3_i (ir[14:12]),
      .srcb_o   (w_srcb_dec)
   );

   assign srcB_SEL  = (state_q == ST_EXEC) ? w_srcb_dec :
                      (state_q == ST_MEM)  ? SRCB_ITYPE : SRCB_RS2;
   assign w_irq     = intr && csr_mie;
   // Timeout fires on the last of MEM_TO_CYCLES consecutive un-acked cycles; an ack in that cycle wins.
   assign w_timeout = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ack &&
                      (cnt_q == TO_W'(MEM_TO_CYCLES - 1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      mem_rden1 = 1'b0;
      mem_rden2 = 1'b0;
      mem_we2   = 1'b0;
      csr_we    = 1'b0;
      int_taken = 1'b0;
      mret_exec = 1'b0;
      bus_err   = 1'b0;
      ill_err   = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_rden1 = 1'b1;
            if (mem_ack)        state_d = ST_EXEC;
            else if (w_timeout) bus_err = 1'b1;
            else                cnt_d   = cnt_q + TO_W'(1);
         end
         ST_EXEC: begin
            state_d = w_irq ? ST_INTR : ST_FETCH;
            case (ir[6:0])
               OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                  rf_we = 1'b1;
                  pc_we = 1'b1;
               end
               OPC_BRANCH: pc_we = 1'b1;
               OPC_STORE: begin
                  mem_we2 = 1'b1;
                  pc_we   = 1'b1;
               end
               OPC_LOAD: begin
                  mem_rden2 = 1'b1;
                  state_d   = ST_MEM;
               end
               OPC_SYSTEM: begin
                  pc_we = 1'b1;
                  if (is_csr_f3(ir[14:12])) begin
                     csr_we = 1'b1;
                     rf_we  = 1'b1;
                  end else if (ir[14:12] == 3'b000 && ir[31:20] == MRET_IMM) begin
                     mret_exec = 1'b1;
                  end else begin
                     ill_err = 1'b1;
                  end
               end
               default: begin
                  ill_err = 1'b1;
                  pc_we   = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            mem_rden2 = 1'b1;
            if (mem_ack) begin
               rf_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = w_irq ? ST_INTR : ST_FETCH;
            end else if (w_timeout) begin
               bus_err = 1'b1;
               pc_we   = 1'b1;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         ST_INTR: begin
            int_taken = 1'b1;
            pc_we     = 1'b1;
            state_d   = ST_FETCH;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_otter_exec_sequencer.sv
`default_nettype none
// tb_otter_exec_sequencer: directed self-checking bench for the OTTER execution sequencer.
// Revision 1.0
module tb_otter_exec_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [31:0] ir;
   logic        mem_ack, intr, csr_mie;
   logic [2:0]  srcB_SEL;
   logic        pc_we, rf_we, mem_rden1, mem_rden2, mem_we2, csr_we;
   logic        int_taken, mret_exec, bus_err, ill_err;
   logic [12:0] obs;
   int          n_vec = 0;
   int          n_err = 0;

   // Output bundle: {srcB[2:0], pc, rf, rden1, rden2, we2, csr, int, mret, bus, ill}
   localparam logic [12:0] PC = 13'h200, RF = 13'h100, R1 = 13'h080, R2 = 13'h040;
   localparam logic [12:0] W2 = 13'h020, CW = 13'h010, IT = 13'h008, MR = 13'h004;
   localparam logic [12:0] BE = 13'h002, IE = 13'h001, Z = 13'h000;

   function automatic logic [12:0] sb(input int n);
      return {n[2:0], 10'b0};
   endfunction

   otter_exec_sequencer #(.MEM_TO_CYCLES(16), .TO_W(5)) dut (
      .CLK(CLK), .RST_N(RST_N), .ir(ir), .mem_ack(mem_ack), .intr(intr), .csr_mie(csr_mie),
      .srcB_SEL(srcB_SEL), .pc_we(pc_we), .rf_we(rf_we), .mem_rden1(mem_rden1),
      .mem_rden2(mem_rden2), .mem_we2(mem_we2), .csr_we(csr_we), .int_taken(int_taken),
      .mret_exec(mret_exec), .bus_err(bus_err), .ill_err(ill_err)
   );

   assign obs = {srcB_SEL, pc_we, rf_we, mem_rden1, mem_rden2, mem_we2, csr_we,
                 int_taken, mret_exec, bus_err, ill_err};

   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [12:0] exp);
      #1;
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      RST_N = 1'b0; ir = 32'h0; mem_ack = 1'b0; intr = 1'b0; csr_mie = 1'b0;
      tick; tick;
      chk("reset_init", Z);
      RST_N = 1'b1;
      chk("init_after_release", Z);
      tick;

      // ADDI x1,x0,5
      ir = 32'h00500093; mem_ack = 1'b1;
      chk("addi_fetch", R1);
      tick; mem_ack = 1'b0;
      chk("addi_exec", sb(1) | RF | PC);
      tick;
      chk("addi_back_fetch", R1);

      // SW
      ir = 32'h0020A223; mem_ack = 1'b1;
      tick; mem_ack = 1'b0;
      chk("sw_exec", sb(2) | W2 | PC);
      tick;

      // AUIPC
      ir = 32'h00000017; mem_ack = 1'b1;
      tick; mem_ack = 1'b0;
      chk("auipc_exec", sb(3) | RF | PC);
      tick;

      // LW with ack after 3 MEM cycles
      ir = 32'h0000A103; mem_ack = 1'b1;
      tick; mem_ack = 1'b0;
      chk("lw_exec", sb(1) | R2);
      tick;
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_wait", sb(1) | R2);
         tick;
      end
      mem_ack = 1'b1;
      chk("lw_mem_ack", sb(1) | R2 | RF | PC);
      tick; mem_ack = 1'b0;
      chk("lw_done_fetch", R1);

      // LW never acked: 16 MEM cycles then timeout
      mem_ack = 1'b1;
      tick; mem_ack = 1'b0;
      tick;
      for (int i = 0; i < 15; i++) begin
         chk("lw_to_wait", sb(1) | R2);
         tick;
      end
      chk("lw_timeout", sb(1) | R2 | PC | BE);
      tick;
      chk("lw_to_fetch", R1);

      // CSRRS with pending enabled interrupt
      ir = 32'h300022F3; mem_ack = 1'b1; intr = 1'b1; csr_mie = 1'b1;
      chk("csr_fetch_no_irq", R1);
      tick; mem_ack = 1'b0;
      chk("csrrs_exec", sb(4) | CW | RF | PC);
      tick;
      chk("csr_intr", IT | PC);
      tick; intr = 1'b0;
      chk("csr_intr_to_fetch", R1);

      // Illegal opcode with interrupt pending: skip then take interrupt
      ir = 32'h0000007F; mem_ack = 1'b1; intr = 1'b1;
      tick; mem_ack = 1'b0;
      chk("ill_exec", PC | IE);
      tick;
      chk("ill_intr", IT | PC);
      tick; intr = 1'b0; csr_mie = 1'b0;

      // Fetch timeout and retry
      ir = 32'h30200073;
      for (int i = 0; i < 15; i++) begin
         chk("fetch_wait", R1);
         tick;
      end
      chk("fetch_timeout", R1 | BE);
      tick;
      // Ack arriving in the timeout cycle wins
      for (int i = 0; i < 15; i++) tick;
      mem_ack = 1'b1;
      chk("fetch_ack_at_timeout", R1);
      tick; mem_ack = 1'b0;
      chk("mret_exec", MR | PC);
      tick;

      // Reset during MEM
      ir = 32'h0000A103; mem_ack = 1'b1;
      tick; mem_ack = 1'b0;
      tick;
      chk("rst_pre_mem", sb(1) | R2);
      RST_N = 1'b0;
      chk("rst_async_drop", Z);
      tick;
      chk("rst_held", Z);
      RST_N = 1'b1;
      chk("rst_release_init", Z);
      tick;
      chk("rst_resume_fetch", R1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
